multicycle_seq: RTL and testbench

//  Main FSM for the multi-cycle MIPS32 datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multicycle_seq_pkg.sv | 32 +++
 rtl/multicycle_seq_mem_req_ctl.sv | 49 ++++
 rtl/multicycle_seq.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_seq_pkg.sv
// Shared encodings for the multi-cycle MIPS32 sequencer: FSM states, decoded classes, PC source selects.
// Pure type definitions; no logic, no latency, no backpressure.
package multicycle_seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_EXC    = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU_R   = 3'd0,
        CLS_ALU_I   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JREG    = 3'd5,
        CLS_NOP     = 3'd6,
        CLS_INVALID = 3'd7
    } cls_e;

    typedef enum logic [1:0] {
        PC_SRC_SEQ = 2'd0,
        PC_SRC_BR  = 2'd1,
        PC_SRC_RS  = 2'd2,
        PC_SRC_EXC = 2'd3
    } pc_src_e;

endpackage

// File: rtl/multicycle_seq_mem_req_ctl.sv
// Memory req/ack helper: req follows active_i (dropped at once by rst), done = req & ack, zero added latency.
// Req holds until ack; with SEQ_EXC_EN a per-request counter flags timeout after MEM_TIMEOUT unacked cycles.
module mem_req_ctl
`ifdef SEQ_EXC_EN
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
)
`endif
(
`ifdef SEQ_EXC_EN
    input  logic clk,
`endif
    input  logic rst,
    input  logic active_i,
    input  logic ack_i,
    output logic req_o,
    output logic done_o,
    output logic timeout_o
);

    assign req_o  = active_i & ~rst;
    assign done_o = req_o & ack_i;

`ifdef SEQ_EXC_EN
    logic [TO_W-1:0] cnt_q, cnt_d;

    // Counter is zero whenever the owning state is not active, so each new request starts fresh.
    always_comb begin
        cnt_d = '0;
        if (req_o && !ack_i) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = req_o & ~ack_i & (cnt_q == TO_W'(MEM_TIMEOUT - 1));
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle MIPS32 sequencer FETCH/DECODE/EXEC/MEM/WB (EXC state + mem timeout with SEQ_EXC_EN); NOP 2 .. LOAD 5 cycles.
// Stalls in FETCH/MEM until ack; every output is forced low while rst is high.
module multicycle_seq
    import multicycle_seq_pkg::*;
`ifdef SEQ_EXC_EN
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  cls,
    input  logic        br_taken,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        alu_en,
    output logic        rf_we,
    output logic        rf_wsel,
    output logic [2:0]  state_o,
`ifdef SEQ_EXC_EN
    output logic        exc_o,
`endif
    output logic [31:0] instret
);

    state_e      state_q, state_d;
    cls_e        cls_q, cls_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;
    logic        imem_done, imem_to;
    logic        dmem_done, dmem_to;

`ifdef SEQ_EXC_EN
    mem_req_ctl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_imem (
        .clk       (clk),
`else
    mem_req_ctl u_imem (
`endif
        .rst       (rst),
        .active_i  (state_q == ST_FETCH),
        .ack_i     (imem_ack),
        .req_o     (imem_req),
        .done_o    (imem_done),
        .timeout_o (imem_to)
    );

`ifdef SEQ_EXC_EN
    mem_req_ctl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_dmem (
        .clk       (clk),
`else
    mem_req_ctl u_dmem (
`endif
        .rst       (rst),
        .active_i  (state_q == ST_MEM),
        .ack_i     (dmem_ack),
        .req_o     (dmem_req),
        .done_o    (dmem_done),
        .timeout_o (dmem_to)
    );

    assign instret_d = instret_q + 32'd1;

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        retire  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_src  = PC_SRC_SEQ;
        alu_en  = 1'b0;
        rf_we   = 1'b0;
        rf_wsel = 1'b0;
        dmem_we = 1'b0;
`ifdef SEQ_EXC_EN
        exc_o   = 1'b0;
`endif
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_done) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = ST_DECODE;
                    end else if (imem_to) begin
                        state_d = ST_EXC;
                    end
                end
                ST_DECODE: begin
                    // Decoder output is registered; it is valid now and captured for the rest of the instruction.
                    cls_d = cls_e'(cls);
                    case (cls_e'(cls))
                        CLS_NOP: begin
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                        CLS_INVALID: begin
`ifdef SEQ_EXC_EN
                            state_d = ST_EXC;
`else
                            retire  = 1'b1;
                            state_d = ST_FETCH;
`endif
                        end
                        default: state_d = ST_EXEC;
                    endcase
                end
                ST_EXEC: begin
                    alu_en = 1'b1;
                    case (cls_q)
                        CLS_ALU_R, CLS_ALU_I: state_d = ST_WB;
                        CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
                        CLS_BRANCH: begin
                            pc_we   = br_taken;
                            pc_src  = PC_SRC_BR;
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                        CLS_JREG: begin
                            pc_we   = 1'b1;
                            pc_src  = PC_SRC_RS;
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                        default: state_d = ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    dmem_we = (cls_q == CLS_STORE);
                    if (dmem_done) begin
                        if (cls_q == CLS_STORE) begin
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end else if (dmem_to) begin
                        state_d = ST_EXC;
                    end
                end
                ST_WB: begin
                    rf_we   = 1'b1;
                    rf_wsel = (cls_q == CLS_LOAD);
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_EXC: begin
`ifdef SEQ_EXC_EN
                    exc_o  = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_EXC;
`endif
                    state_d = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_NOP;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            if (retire) begin
                instret_q <= instret_d;
            end
        end
    end

    assign state_o = rst ? 3'd0 : state_q;
    assign instret = rst ? 32'd0 : instret_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Scoreboard bench for multicycle_seq: per-cycle expected output vectors are queued per instruction and
// compared as the DUT steps; SEQ_EXC_EN adds the imem timeout scenario.
module tb_multicycle_seq;
    import multicycle_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cls = 3'd0;
    logic        br_taken = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_en, rf_we, rf_wsel;
    logic [1:0]  pc_src;
    logic [2:0]  state_o;
    logic [31:0] instret;
    logic        exc_sig;
`ifdef SEQ_EXC_EN
    logic        exc_o;
    assign exc_sig = exc_o;
`else
    assign exc_sig = 1'b0;
`endif

    multicycle_seq dut (
        .clk      (clk),
        .rst      (rst),
        .cls      (cls),
        .br_taken (br_taken),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .imem_req (imem_req),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .pc_src   (pc_src),
        .alu_en   (alu_en),
        .rf_we    (rf_we),
        .rf_wsel  (rf_wsel),
        .state_o  (state_o),
`ifdef SEQ_EXC_EN
        .exc_o    (exc_o),
`endif
        .instret  (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_en;
        logic       rf_we;
        logic       rf_wsel;
        logic       exc;
    } obs_t;

    typedef struct {
        obs_t exp;
        logic ia;
        logic da;
    } cyc_t;

    cyc_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_instret;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.st       = state_o;
        o.imem_req = imem_req;
        o.dmem_req = dmem_req;
        o.dmem_we  = dmem_we;
        o.ir_we    = ir_we;
        o.pc_we    = pc_we;
        o.pc_src   = pc_src;
        o.alu_en   = alu_en;
        o.rf_we    = rf_we;
        o.rf_wsel  = rf_wsel;
        o.exc      = exc_sig;
        return o;
    endfunction

    function automatic obs_t mk(input logic [2:0] st);
        obs_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic push(input obs_t o, input logic ia, input logic da);
        cyc_t c;
        c.exp = o;
        c.ia  = ia;
        c.da  = da;
        sb.push_back(c);
    endtask

    // Expected cycle-by-cycle trace of one instruction; acks on non-requesting cycles are random noise.
    task automatic build_instr(input logic [2:0] c, input logic br, input int iw, input int dw, output bit ret);
        obs_t o;
        ret = 1'b1;
        for (int i = 0; i < iw; i++) begin
            o = mk(ST_FETCH); o.imem_req = 1'b1;
            push(o, 1'b0, rnd());
        end
        o = mk(ST_FETCH); o.imem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
        push(o, 1'b1, rnd());
        push(mk(ST_DECODE), rnd(), rnd());
        if (c == CLS_INVALID) begin
`ifdef SEQ_EXC_EN
            o = mk(ST_EXC); o.exc = 1'b1; o.pc_we = 1'b1; o.pc_src = 2'd3;
            push(o, rnd(), rnd());
            ret = 1'b0;
`endif
        end else if (c != CLS_NOP) begin
            o = mk(ST_EXEC); o.alu_en = 1'b1;
            if (c == CLS_BRANCH) begin o.pc_we = br; o.pc_src = 2'd1; end
            if (c == CLS_JREG) begin o.pc_we = 1'b1; o.pc_src = 2'd2; end
            push(o, rnd(), rnd());
            if (c == CLS_LOAD || c == CLS_STORE) begin
                o = mk(ST_MEM); o.dmem_req = 1'b1; o.dmem_we = (c == CLS_STORE);
                for (int i = 0; i < dw; i++) push(o, rnd(), 1'b0);
                push(o, rnd(), 1'b1);
            end
            if (c == CLS_ALU_R || c == CLS_ALU_I || c == CLS_LOAD) begin
                o = mk(ST_WB); o.rf_we = 1'b1; o.rf_wsel = (c == CLS_LOAD);
                push(o, rnd(), rnd());
            end
        end
    endtask

    // Entered at posedge+1; cls is scrambled after DECODE and br_taken inverted outside EXEC.
    task automatic run_trace(input logic [2:0] c, input logic br, input string tag);
        cyc_t e;
        bit   past_dec;
        int   k;
        past_dec = 1'b0;
        k = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            imem_ack = e.ia;
            dmem_ack = e.da;
            cls      = past_dec ? ~c : c;
            br_taken = (e.exp.st == ST_EXEC) ? br : ~br;
            @(negedge clk);
            check_eq($sformatf("%s.c%0d", tag, k), 32'(observe()), 32'(e.exp));
            if (e.exp.st == ST_DECODE) past_dec = 1'b1;
            k++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input logic [2:0] c, input logic br, input int iw, input int dw, input string tag);
        bit ret;
        build_instr(c, br, iw, dw, ret);
        run_trace(c, br, tag);
        if (ret) exp_instret = exp_instret + 32'd1;
        check_eq({tag, ".instret"}, instret, exp_instret);
    endtask

    initial begin
        obs_t o;
        bit   ret;
        exp_instret = '0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("rst.outs", 32'(observe()), 32'd0);
            check_eq("rst.instret", instret, 32'd0);
        end
        rst = 1'b0;
        #1;
        check_eq("rel.instret", instret, 32'd0);

        run_instr(CLS_ALU_R,   1'b0, 0, 0, "alu_r");
        run_instr(CLS_LOAD,    1'b0, 0, 3, "load_dw3");
        run_instr(CLS_BRANCH,  1'b1, 0, 0, "br_taken");
        run_instr(CLS_BRANCH,  1'b0, 0, 0, "br_not");
        run_instr(CLS_ALU_I,   1'b0, 2, 0, "alu_i_iw2");
        run_instr(CLS_STORE,   1'b0, 1, 2, "store");
        run_instr(CLS_JREG,    1'b0, 0, 0, "jreg");
        run_instr(CLS_NOP,     1'b0, 0, 0, "nop");
        run_instr(CLS_INVALID, 1'b0, 0, 0, "invalid");
        run_instr(CLS_LOAD,    1'b0, 0, 0, "load_zw");
        run_instr(CLS_STORE,   1'b0, 0, 0, "store_zw");

        // Reset while a load is stalled in MEM.
        build_instr(CLS_LOAD, 1'b0, 0, 5, ret);
        while (sb.size() > 5) void'(sb.pop_back());
        run_trace(CLS_LOAD, 1'b0, "rst_mid");
        dmem_ack = 1'b0;
        imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rst_mid.dmem_req", 32'(dmem_req), 32'd0);
        check_eq("rst_mid.outs", 32'(observe()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_mid.state", 32'(state_o), 32'(ST_FETCH));
        check_eq("rst_mid.imem_req", 32'(imem_req), 32'd1);
        check_eq("rst_mid.instret", instret, 32'd0);
        exp_instret = '0;
        run_instr(CLS_NOP, 1'b0, 0, 0, "post_rst_nop");

`ifdef SEQ_EXC_EN
        for (int i = 0; i < 16; i++) begin
            o = mk(ST_FETCH); o.imem_req = 1'b1;
            push(o, 1'b0, rnd());
        end
        o = mk(ST_EXC); o.exc = 1'b1; o.pc_we = 1'b1; o.pc_src = 2'd3;
        push(o, 1'b0, rnd());
        run_trace(CLS_NOP, 1'b0, "imem_to");
        check_eq("imem_to.state", 32'(state_o), 32'(ST_FETCH));
        check_eq("imem_to.instret", instret, exp_instret);
        run_instr(CLS_ALU_R, 1'b0, 0, 0, "after_exc");
`endif

        // instret wrap.
        imem_ack = 1'b0;
        force dut.instret_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.instret_q;
        #1;
        check_eq("wrap.preload", instret, 32'hFFFF_FFFF);
        exp_instret = 32'hFFFF_FFFF;
        run_instr(CLS_NOP, 1'b0, 0, 0, "wrap_nop");
        check_eq("wrap.zero", instret, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1);
    end

endmodule
